two_to_four: RTL

Stream width converter for the radix-2 pipelined FFT datapath. It performs the inverse of the four-lane to two-lane stage: two DATA_W samples arrive per handshake beat, and every two accepted beats are packed into one four-lane output word. Valid/ready handshakes on both sides allow backpressure. An optional start-of-frame marker realigns the packing and flags any discarded half-word. The block sits between a 2-lane butterfly stage and a 4-lane stage.

---
 rtl/fft_stream_pkg.sv | 18 +
 rtl/two_to_four.sv | 106 ++++++++++
 2 files changed

// File: rtl/fft_stream_pkg.sv
`default_nettype none
// ============================================================================
// fft_stream_pkg : shared constants and types for the FFT stream converters
// Revision 1.0
// ============================================================================
package fft_stream_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int IN_LANES   = 2;
  localparam int OUT_LANES  = 4;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } phase_e;

endpackage
`default_nettype wire

// File: rtl/two_to_four.sv
`default_nettype none
// ============================================================================
// two_to_four : packs two 2-lane handshake beats into one 4-lane output word
// Revision 1.0
// ============================================================================
module two_to_four
  import fft_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_lane0,
  input  logic [DATA_W-1:0] in_lane1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_lane0,
  output logic [DATA_W-1:0] out_lane1,
  output logic [DATA_W-1:0] out_lane2,
  output logic [DATA_W-1:0] out_lane3,
  output logic              drop_err,
  output logic [CNT_W-1:0]  word_cnt
);

  phase_e            phase_q, phase_d;
  logic [DATA_W-1:0] hold_q [IN_LANES];
  logic [DATA_W-1:0] hold_d [IN_LANES];
  logic [DATA_W-1:0] out_q  [OUT_LANES];
  logic [DATA_W-1:0] out_d  [OUT_LANES];
  logic              out_valid_q, out_valid_d;
  logic              drop_err_q, drop_err_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

  logic accept;
  logic handoff;

  // A second beat may only arrive once the output register is free or leaving.
  assign in_ready = (phase_q == EMPTY) || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid_q && out_ready;

  always_comb begin
    phase_d     = phase_q;
    hold_d      = hold_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    drop_err_d  = 1'b0;
    word_cnt_d  = word_cnt_q + CNT_W'(handoff);

    if (handoff) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (phase_q == EMPTY) begin
        hold_d[0] = in_lane0;
        hold_d[1] = in_lane1;
        phase_d   = HALF;
      end else if (in_sof) begin
        // A new frame start discards the stale half and realigns on this beat.
        hold_d[0]  = in_lane0;
        hold_d[1]  = in_lane1;
        drop_err_d = 1'b1;
      end else begin
        out_d[0]    = hold_q[0];
        out_d[1]    = hold_q[1];
        out_d[2]    = in_lane0;
        out_d[3]    = in_lane1;
        out_valid_d = 1'b1;
        phase_d     = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= EMPTY;
      hold_q      <= '{default: '0};
      out_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      drop_err_q  <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      drop_err_q  <= drop_err_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_lane0 = out_q[0];
  assign out_lane1 = out_q[1];
  assign out_lane2 = out_q[2];
  assign out_lane3 = out_q[3];
  assign drop_err  = drop_err_q;
  assign word_cnt  = word_cnt_q;

endmodule
`default_nettype wire
